// File: rtl/axi_lite_arb_pkg.sv
// Shared types and response codes for the 2x1 AXI4-Lite arbiter.
// Optional build macro AXIL_ARB_FIXED_PRIO_EN is consumed by axi_lite_arb_pick.
package axi_lite_arb_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_XFER = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_arbiter_2x1_if.sv
// AXI4-Lite bus bundle; "master" is the view of a bus master, "slave" the view of a register slave.
interface axi_lite_arbiter_2x1_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_arb_pick.sv
// Two-way request picker. Round-robin pointer flips to the other master on each completed response;
// with AXIL_ARB_FIXED_PRIO_EN defined, M0 always wins and the pointer does not exist.
module axi_lite_arb_pick (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  logic       i_owner,
  output logic       o_gnt
);
`ifdef AXIL_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = ^{i_clk, i_rst, i_done, i_owner, i_req[1]};

  // M0 first; the grant only matters when some request is present
  always_comb begin
    if (i_req[0]) begin
      o_gnt = 1'b0;
    end else begin
      o_gnt = 1'b1;
    end
  end
`else
  logic r_ptr;

  // pointer names the master preferred on a tie
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_done) begin
      r_ptr <= ~i_owner;
    end
  end

  // tie goes to the pointer, otherwise the lone requester
  always_comb begin
    case (i_req)
      2'b11:   o_gnt = r_ptr;
      2'b10:   o_gnt = 1'b1;
      default: o_gnt = 1'b0;
    endcase
  end
`endif
endmodule

// File: rtl/axi_lite_arbiter_2x1.sv
// 2-master -> 1-slave AXI4-Lite arbiter with independent read and write ownership.
// Build option AXIL_ARB_FIXED_PRIO_EN selects fixed M0 priority instead of round-robin.
module axi_lite_arbiter_2x1
  import axi_lite_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  axi_lite_arbiter_2x1_if.slave         m0,
  axi_lite_arbiter_2x1_if.slave         m1,
  axi_lite_arbiter_2x1_if.master        s,
  output logic                          rd_busy,
  output logic                          rd_owner,
  output logic                          wr_busy,
  output logic                          wr_owner
);

  rd_state_t r_rd_state, w_rd_next;
  logic      r_rd_owner, w_rd_owner_nxt, r_rd_busy;
  logic [1:0] w_rd_req;
  logic      w_rd_gnt, w_own_arvalid, w_own_rready, w_ar_hs, w_r_hs;

  wr_state_t r_wr_state, w_wr_next;
  logic      r_wr_owner, w_wr_owner_nxt, r_wr_busy, r_aw_done, r_w_done;
  logic [1:0] w_wr_req;
  logic      w_wr_gnt, w_own_awvalid, w_own_wvalid, w_own_bready;
  logic      w_aw_hs, w_w_hs, w_b_hs;

  assign rd_busy  = r_rd_busy;
  assign rd_owner = r_rd_owner;
  assign wr_busy  = r_wr_busy;
  assign wr_owner = r_wr_owner;

  assign w_rd_req      = {m1.arvalid, m0.arvalid};
  assign w_own_arvalid = r_rd_owner ? m1.arvalid : m0.arvalid;
  assign w_own_rready  = r_rd_owner ? m1.rready : m0.rready;
  assign w_ar_hs       = (r_rd_state == RD_ADDR) && w_own_arvalid && s.arready;
  assign w_r_hs        = (r_rd_state == RD_DATA) && s.rvalid && w_own_rready;

  axi_lite_arb_pick u_rd_pick (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_req   (w_rd_req),
    .i_done  (w_r_hs),
    .i_owner (r_rd_owner),
    .o_gnt   (w_rd_gnt)
  );

  // read path next state and owner capture
  always_comb begin
    w_rd_next      = r_rd_state;
    w_rd_owner_nxt = r_rd_owner;
    case (r_rd_state)
      RD_IDLE: begin
        if (|w_rd_req) begin
          w_rd_next      = RD_ADDR;
          w_rd_owner_nxt = w_rd_gnt;
        end else begin
          w_rd_next = RD_IDLE;
        end
      end
      RD_ADDR: begin
        if (w_ar_hs) begin
          w_rd_next = RD_DATA;
        end else begin
          w_rd_next = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (w_r_hs) begin
          w_rd_next = RD_IDLE;
        end else begin
          w_rd_next = RD_DATA;
        end
      end
      default: w_rd_next = RD_IDLE;
    endcase
  end

  // read path state register
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rd_state <= RD_IDLE;
      r_rd_owner <= 1'b0;
      r_rd_busy  <= 1'b0;
    end else begin
      r_rd_state <= w_rd_next;
      r_rd_owner <= w_rd_owner_nxt;
      r_rd_busy  <= (w_rd_next != RD_IDLE);
    end
  end

  // read channel routing; everything not owned stays at zero
  always_comb begin
    s.araddr   = {ADDR_W{1'b0}};
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rdata   = {DATA_W{1'b0}};
    m1.rdata   = {DATA_W{1'b0}};
    m0.rresp   = AXI_RESP_OKAY;
    m1.rresp   = AXI_RESP_OKAY;
    m0.rvalid  = 1'b0;
    m1.rvalid  = 1'b0;
    case (r_rd_state)
      RD_ADDR: begin
        s.araddr  = r_rd_owner ? m1.araddr : m0.araddr;
        s.arvalid = w_own_arvalid;
        if (r_rd_owner) begin
          m1.arready = s.arready;
        end else begin
          m0.arready = s.arready;
        end
      end
      RD_DATA: begin
        s.rready = w_own_rready;
        if (r_rd_owner) begin
          m1.rdata  = s.rdata;
          m1.rresp  = s.rresp;
          m1.rvalid = s.rvalid;
        end else begin
          m0.rdata  = s.rdata;
          m0.rresp  = s.rresp;
          m0.rvalid = s.rvalid;
        end
      end
      default: begin
      end
    endcase
  end

  assign w_wr_req      = {m1.awvalid | m1.wvalid, m0.awvalid | m0.wvalid};
  assign w_own_awvalid = r_wr_owner ? m1.awvalid : m0.awvalid;
  assign w_own_wvalid  = r_wr_owner ? m1.wvalid : m0.wvalid;
  assign w_own_bready  = r_wr_owner ? m1.bready : m0.bready;
  assign w_aw_hs = (r_wr_state == WR_XFER) && !r_aw_done && w_own_awvalid && s.awready;
  assign w_w_hs  = (r_wr_state == WR_XFER) && !r_w_done && w_own_wvalid && s.wready;
  assign w_b_hs  = (r_wr_state == WR_RESP) && s.bvalid && w_own_bready;

  axi_lite_arb_pick u_wr_pick (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_req   (w_wr_req),
    .i_done  (w_b_hs),
    .i_owner (r_wr_owner),
    .o_gnt   (w_wr_gnt)
  );

  // write path next state; AW and W may complete in either order
  always_comb begin
    w_wr_next      = r_wr_state;
    w_wr_owner_nxt = r_wr_owner;
    case (r_wr_state)
      WR_IDLE: begin
        if (|w_wr_req) begin
          w_wr_next      = WR_XFER;
          w_wr_owner_nxt = w_wr_gnt;
        end else begin
          w_wr_next = WR_IDLE;
        end
      end
      WR_XFER: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_wr_next = WR_RESP;
        end else begin
          w_wr_next = WR_XFER;
        end
      end
      WR_RESP: begin
        if (w_b_hs) begin
          w_wr_next = WR_IDLE;
        end else begin
          w_wr_next = WR_RESP;
        end
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  // write path state register and per-channel done flags
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_state <= WR_IDLE;
      r_wr_owner <= 1'b0;
      r_wr_busy  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      r_wr_owner <= w_wr_owner_nxt;
      r_wr_busy  <= (w_wr_next != WR_IDLE);
      if (r_wr_state == WR_IDLE) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        r_aw_done <= r_aw_done | w_aw_hs;
        r_w_done  <= r_w_done | w_w_hs;
      end
    end
  end

  // write channel routing; a finished channel is gated off until the next grant
  always_comb begin
    s.awaddr   = {ADDR_W{1'b0}};
    s.awvalid  = 1'b0;
    s.wdata    = {DATA_W{1'b0}};
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    m0.awready = 1'b0;
    m1.awready = 1'b0;
    m0.wready  = 1'b0;
    m1.wready  = 1'b0;
    m0.bresp   = AXI_RESP_OKAY;
    m1.bresp   = AXI_RESP_OKAY;
    m0.bvalid  = 1'b0;
    m1.bvalid  = 1'b0;
    case (r_wr_state)
      WR_XFER: begin
        s.awaddr  = r_wr_owner ? m1.awaddr : m0.awaddr;
        s.awvalid = w_own_awvalid && !r_aw_done;
        s.wdata   = r_wr_owner ? m1.wdata : m0.wdata;
        s.wvalid  = w_own_wvalid && !r_w_done;
        if (r_wr_owner) begin
          m1.awready = s.awready && !r_aw_done;
          m1.wready  = s.wready && !r_w_done;
        end else begin
          m0.awready = s.awready && !r_aw_done;
          m0.wready  = s.wready && !r_w_done;
        end
      end
      WR_RESP: begin
        s.bready = w_own_bready;
        if (r_wr_owner) begin
          m1.bresp  = s.bresp;
          m1.bvalid = s.bvalid;
        end else begin
          m0.bresp  = s.bresp;
          m0.bvalid = s.bvalid;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter_2x1.sv
// Directed bench for axi_lite_arbiter_2x1; the slave side is driven by hand cycle by cycle.
module tb_axi_lite_arbiter_2x1;
  import axi_lite_arb_pkg::*;

`ifdef AXIL_ARB_FIXED_PRIO_EN
  localparam logic EXP_2ND = 1'b0;
`else
  localparam logic EXP_2ND = 1'b1;
`endif

  logic aclk;
  logic areset;
  logic rd_busy, rd_owner, wr_busy, wr_owner;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_addr;

  axi_lite_arbiter_2x1_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  axi_lite_arbiter_2x1_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  axi_lite_arbiter_2x1_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  axi_lite_arbiter_2x1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .m0       (m0_if),
    .m1       (m1_if),
    .s        (s_if),
    .rd_busy  (rd_busy),
    .rd_owner (rd_owner),
    .wr_busy  (wr_busy),
    .wr_owner (wr_owner)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.araddr = 32'h0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b0;
    m0_if.awaddr = 32'h0; m0_if.awvalid = 1'b0; m0_if.wdata = 32'h0;
    m0_if.wvalid = 1'b0;  m0_if.bready = 1'b0;
    m1_if.araddr = 32'h0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b0;
    m1_if.awaddr = 32'h0; m1_if.awvalid = 1'b0; m1_if.wdata = 32'h0;
    m1_if.wvalid = 1'b0;  m1_if.bready = 1'b0;
    s_if.arready = 1'b0;  s_if.rdata = 32'h0; s_if.rresp = 2'b00; s_if.rvalid = 1'b0;
    s_if.awready = 1'b0;  s_if.wready = 1'b0; s_if.bresp = 2'b00; s_if.bvalid = 1'b0;
  endtask

  task automatic reset_dut();
    areset = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    areset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    areset   = 1'b1;
    clear_inputs();
    cyc();
    reset_dut();

    // reset state
    #2;
    check_val("rst_rd_busy", {31'd0, rd_busy}, 32'd0);
    check_val("rst_wr_busy", {31'd0, wr_busy}, 32'd0);
    check_val("rst_rd_owner", {31'd0, rd_owner}, 32'd0);
    check_val("rst_wr_owner", {31'd0, wr_owner}, 32'd0);
    check_val("rst_s_arvalid", {31'd0, s_if.arvalid}, 32'd0);
    check_val("rst_s_awvalid", {31'd0, s_if.awvalid}, 32'd0);
    check_val("rst_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
    cyc();

    // M0 reads 0x8 alone
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8;
    #2 check_val("t1_arb_cycle_s_arvalid", {31'd0, s_if.arvalid}, 32'd0);
    cyc();
    s_if.arready = 1'b1;
    #2;
    check_val("t1_s_arvalid", {31'd0, s_if.arvalid}, 32'd1);
    check_val("t1_s_araddr", s_if.araddr, 32'h8);
    check_val("t1_m0_arready", {31'd0, m0_if.arready}, 32'd1);
    check_val("t1_rd_busy", {31'd0, rd_busy}, 32'd1);
    cyc();
    m0_if.arvalid = 1'b0; s_if.arready = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'hDEAD_BEEF; s_if.rresp = AXI_RESP_OKAY; m0_if.rready = 1'b1;
    #2;
    check_val("t1_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd1);
    check_val("t1_m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    check_val("t1_m1_rvalid", {31'd0, m1_if.rvalid}, 32'd0);
    check_val("t1_s_rready", {31'd0, s_if.rready}, 32'd1);
    cyc();
    s_if.rvalid = 1'b0; m0_if.rready = 1'b0;
    #2 check_val("t1_done_rd_busy", {31'd0, rd_busy}, 32'd0);
    reset_dut();

    // simultaneous reads; M0 re-asserts while its first read is in flight
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h10;
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h14;
    cyc();
    s_if.arready = 1'b1;
    #2;
    check_val("t2_first_owner", {31'd0, rd_owner}, 32'd0);
    check_val("t2_first_addr", s_if.araddr, 32'h10);
    check_val("t2_m1_arready", {31'd0, m1_if.arready}, 32'd0);
    cyc();
    s_if.arready = 1'b0; m0_if.araddr = 32'h18;
    s_if.rvalid = 1'b1; s_if.rdata = 32'h11; m0_if.rready = 1'b1;
    #2 check_val("t2_m0_rdata", m0_if.rdata, 32'h11);
    cyc();
    s_if.rvalid = 1'b0; m0_if.rready = 1'b0;
    cyc();
    exp_addr = EXP_2ND ? 32'h14 : 32'h18;
    #2;
    check_val("t2_second_owner", {31'd0, rd_owner}, {31'd0, EXP_2ND});
    check_val("t2_second_addr", s_if.araddr, exp_addr);
    reset_dut();

    // M1 write: AW three cycles ahead of W
    m1_if.awvalid = 1'b1; m1_if.awaddr = 32'hC;
    s_if.awready = 1'b1; s_if.wready = 1'b1;
    #2 check_val("t3_arb_s_awvalid", {31'd0, s_if.awvalid}, 32'd0);
    cyc();
    #2;
    check_val("t3_s_awvalid", {31'd0, s_if.awvalid}, 32'd1);
    check_val("t3_s_awaddr", s_if.awaddr, 32'hC);
    check_val("t3_m1_awready", {31'd0, m1_if.awready}, 32'd1);
    check_val("t3_s_wvalid_early", {31'd0, s_if.wvalid}, 32'd0);
    check_val("t3_wr_owner", {31'd0, wr_owner}, 32'd1);
    cyc();
    m1_if.awvalid = 1'b0; s_if.bvalid = 1'b1; s_if.bresp = AXI_RESP_SLVERR;
    #2;
    check_val("t3_aw_gated", {31'd0, s_if.awvalid}, 32'd0);
    check_val("t3_m1_bvalid_early", {31'd0, m1_if.bvalid}, 32'd0);
    cyc();
    m1_if.wvalid = 1'b1; m1_if.wdata = 32'hA5A5;
    #2;
    check_val("t3_s_wvalid", {31'd0, s_if.wvalid}, 32'd1);
    check_val("t3_s_wdata", s_if.wdata, 32'hA5A5);
    check_val("t3_m1_bvalid_xfer", {31'd0, m1_if.bvalid}, 32'd0);
    cyc();
    m1_if.wvalid = 1'b0; m1_if.bready = 1'b1;
    #2;
    check_val("t3_m1_bvalid", {31'd0, m1_if.bvalid}, 32'd1);
    check_val("t3_m1_bresp", {30'd0, m1_if.bresp}, {30'd0, AXI_RESP_SLVERR});
    check_val("t3_m0_bvalid", {31'd0, m0_if.bvalid}, 32'd0);
    check_val("t3_s_bready", {31'd0, s_if.bready}, 32'd1);
    cyc();
    s_if.bvalid = 1'b0; m1_if.bready = 1'b0;
    #2 check_val("t3_done_wr_busy", {31'd0, wr_busy}, 32'd0);
    reset_dut();

    // concurrent M0 read and M1 write
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h4;
    m1_if.awvalid = 1'b1; m1_if.awaddr = 32'h0; m1_if.wvalid = 1'b1; m1_if.wdata = 32'h1234;
    s_if.arready = 1'b1; s_if.awready = 1'b1; s_if.wready = 1'b1;
    cyc();
    #2;
    check_val("t4_rd_owner", {31'd0, rd_owner}, 32'd0);
    check_val("t4_wr_owner", {31'd0, wr_owner}, 32'd1);
    check_val("t4_s_araddr", s_if.araddr, 32'h4);
    check_val("t4_s_wdata", s_if.wdata, 32'h1234);
    check_val("t4_busy_both", {30'd0, rd_busy, wr_busy}, 32'd3);
    cyc();
    clear_inputs();
    s_if.rvalid = 1'b1; s_if.rdata = 32'h55; m0_if.rready = 1'b1;
    s_if.bvalid = 1'b1; m1_if.bready = 1'b1;
    #2;
    check_val("t4_m0_rdata", m0_if.rdata, 32'h55);
    check_val("t4_m1_bvalid", {31'd0, m1_if.bvalid}, 32'd1);
    cyc();
    clear_inputs();
    #2 check_val("t4_idle_both", {30'd0, rd_busy, wr_busy}, 32'd0);
    reset_dut();

    // M0 holds off bready; pending M1 write waits then wins
    m0_if.awvalid = 1'b1; m0_if.awaddr = 32'h20; m0_if.wvalid = 1'b1; m0_if.wdata = 32'h77;
    s_if.awready = 1'b1; s_if.wready = 1'b1;
    cyc();
    m1_if.awvalid = 1'b1; m1_if.awaddr = 32'h24;
    #2 check_val("t5_m1_awready_xfer", {31'd0, m1_if.awready}, 32'd0);
    cyc();
    m0_if.awvalid = 1'b0; m0_if.wvalid = 1'b0; s_if.bvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      check_val("t5_s_bready_hold", {31'd0, s_if.bready}, 32'd0);
      check_val("t5_wr_owner_hold", {31'd0, wr_owner}, 32'd0);
      check_val("t5_m0_bvalid", {31'd0, m0_if.bvalid}, 32'd1);
      check_val("t5_m1_awready_wait", {31'd0, m1_if.awready}, 32'd0);
      cyc();
    end
    m0_if.bready = 1'b1;
    #2 check_val("t5_s_bready", {31'd0, s_if.bready}, 32'd1);
    cyc();
    m0_if.bready = 1'b0; s_if.bvalid = 1'b0;
    cyc();
    #2;
    check_val("t5_m1_granted", {31'd0, wr_owner}, 32'd1);
    check_val("t5_m1_awaddr", s_if.awaddr, 32'h24);
    reset_dut();

    // reset during RD_DATA, then a fresh read
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h28;
    cyc();
    s_if.arready = 1'b1;
    cyc();
    m0_if.arvalid = 1'b0; s_if.arready = 1'b0; s_if.rvalid = 1'b1; s_if.rdata = 32'h99;
    #2 check_val("t6_m0_rvalid_pre", {31'd0, m0_if.rvalid}, 32'd1);
    areset = 1'b1;
    cyc();
    #2;
    check_val("t6_rd_busy", {31'd0, rd_busy}, 32'd0);
    check_val("t6_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
    check_val("t6_valids", {29'd0, s_if.arvalid, s_if.awvalid, s_if.wvalid}, 32'd0);
    areset = 1'b0; s_if.rvalid = 1'b0;
    cyc();
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h30;
    cyc();
    s_if.arready = 1'b1;
    #2 check_val("t6_fresh_araddr", s_if.araddr, 32'h30);
    cyc();
    m1_if.arvalid = 1'b0; s_if.arready = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'hCAFE; m1_if.rready = 1'b1;
    #2 check_val("t6_fresh_rdata", m1_if.rdata, 32'hCAFE);
    cyc();
    clear_inputs();
    #2 check_val("t6_fresh_done", {31'd0, rd_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
